// File: rtl/bcd_pkg.sv
// Shared types and nibble helpers for the BCD scan counter.
// Every digit cell and the top import these so the BCD rules live in one place.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    // Codes 10..15 are not decimal digits; collapse them to zero.
    function automatic bcd_t bcd_sanitize(input bcd_t nib);
        return (nib > BCD_MAX) ? BCD_ZERO : nib;
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t nib);
        return (nib >= BCD_MAX) ? BCD_ZERO : bcd_t'(nib + 4'd1);
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t nib);
        return (nib == BCD_ZERO) ? BCD_MAX : bcd_t'(nib - 4'd1);
    endfunction

    // Digit value that allows a step to ripple into the next digit.
    function automatic logic bcd_is_term(input bcd_t nib, input logic up);
        return up ? (nib == BCD_MAX) : (nib == BCD_ZERO);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter: load, step up/down with wrap, and a
// terminal flag that lets the step ripple into the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  bcd_t load_nib,
    input  logic step,
    input  logic up,
    output bcd_t nib_o,
    output logic term_o
);

    bcd_t r_nib_q;
    bcd_t w_nib_d;

    // Load has priority over step so a simultaneous request never counts.
    always_comb begin
        w_nib_d = r_nib_q;
        if (load) begin
            w_nib_d = bcd_sanitize(load_nib);
        end else if (step) begin
            w_nib_d = up ? bcd_inc(r_nib_q) : bcd_dec(r_nib_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nib_q <= BCD_ZERO;
        end else begin
            r_nib_q <= w_nib_d;
        end
    end

    assign nib_o  = r_nib_q;
    assign term_o = bcd_is_term(r_nib_q, up);

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner that
// presents one digit at a time on A/B/C/D together with a one-hot select.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  carry_o,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // ------------------------------------------------------------------
    // Counter: ripple enable through the digit cells
    // ------------------------------------------------------------------
    logic              w_step_en;
    logic [DIGITS:0]   w_lower;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_step;

    assign w_step_en  = en & ~load;
    assign w_lower[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .load_nib (load_val[4*gi +: 4]),
            .step     (w_step[gi]),
            .up       (up),
            .nib_o    (count_o[4*gi +: 4]),
            .term_o   (w_term[gi])
        );

        assign w_step[gi]    = w_step_en & w_lower[gi];
        assign w_lower[gi+1] = w_lower[gi] & w_term[gi];
    end

    logic r_carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_q <= 1'b0;
        end else begin
            r_carry_q <= w_step_en & w_lower[DIGITS];
        end
    end

    assign carry_o = r_carry_q;

    // ------------------------------------------------------------------
    // Scan divider and digit index, free-running from reset
    // ------------------------------------------------------------------
    logic [DivW-1:0] r_div_q;
    logic [DivW-1:0] w_div_d;
    logic            w_div_term;
    logic [IdxW-1:0] r_idx_q;
    logic [IdxW-1:0] w_idx_d;

    assign w_div_term = (r_div_q == DivW'(SCAN_DIV - 1));

    always_comb begin
        w_div_d = r_div_q + 1'b1;
        w_idx_d = r_idx_q;
        if (w_div_term) begin
            w_div_d = '0;
            if (r_idx_q == IdxW'(DIGITS - 1)) begin
                w_idx_d = '0;
            end else begin
                w_idx_d = r_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_q <= '0;
            r_idx_q <= '0;
        end else begin
            r_div_q <= w_div_d;
            r_idx_q <= w_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mux: select and code both follow the next index so they
    // always change on the same edge.
    // ------------------------------------------------------------------
    bcd_t              w_nib_sel;
    logic [DIGITS-1:0] w_sel_d;

    always_comb begin
        w_nib_sel = BCD_ZERO;
        w_sel_d   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_d == IdxW'(i)) begin
                w_nib_sel  = count_o[4*i +: 4];
                w_sel_d[i] = 1'b1;
            end
        end
    end

    bcd_t              r_abcd_q;
    logic [DIGITS-1:0] r_sel_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_abcd_q <= BCD_ZERO;
            r_sel_q  <= DIGITS'(1);
        end else begin
            r_abcd_q <= w_nib_sel;
            r_sel_q  <= w_sel_d;
        end
    end

    assign A         = r_abcd_q[3];
    assign B         = r_abcd_q[2];
    assign C         = r_abcd_q[1];
    assign D         = r_abcd_q[0];
    assign digit_sel = r_sel_q;

endmodule
